adc128s022_spi_reader: RTL

SPI master that reads the board's 8-channel, 12-bit ADC128S022 ADC.
It converts serial frames into a 12-bit parallel sample with a tag for the channel it came from.
data_out connects directly to the 12-bit in_port of the ADC-data PIO, so the NIOS II can read the latest conversion over Avalon.
The block is the producer end of that PIO input path.

---
 rtl/adc_spi_pkg.sv | 33 +++
 rtl/adc_spi_phase_gen.sv | 51 +++++
 rtl/adc128s022_spi_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC128S022 SPI reader.
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS   = 16;
    localparam int unsigned DATA_W       = 12;
    localparam int unsigned LEAD_ZEROS   = 4;
    localparam int unsigned BIT_IDX_W    = $clog2(FRAME_BITS);

    // Position of the 3-bit channel address inside the 16-bit DIN frame.
    localparam logic [BIT_IDX_W-1:0] ADDR_MSB_POS = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } state_t;

    // DIN value for frame bit k: address MSB first at 13:11, zero elsewhere.
    function automatic logic frame_bit(input logic [BIT_IDX_W-1:0] k, input logic [2:0] ch);
        logic b;
        b = 1'b0;
        if (k == ADDR_MSB_POS) begin
            b = ch[2];
        end else if (k == ADDR_MSB_POS - 4'd1) begin
            b = ch[1];
        end else if (k == ADDR_MSB_POS - 4'd2) begin
            b = ch[0];
        end
        return b;
    endfunction

endpackage

// File: rtl/adc_spi_phase_gen.sv
// SCLK phase generator: divides clk into CLK_DIV-long phases and produces
// the registered SCLK plus one-clk strobes on the clk where SCLK falls/rises.
module adc_spi_phase_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic run,        // counter runs while high, held at zero otherwise
    input  logic fall_ok,    // permit SCLK to fall at the end of a high phase
    output logic phase_end,
    output logic fall_tick,
    output logic rise_tick,
    output logic sclk
);

    localparam int unsigned     CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    // Phase counter and SCLK next-state.
    always_comb begin
        phase_end = run && (cnt_q == CNT_MAX);
        fall_tick = phase_end && sclk_q && fall_ok;
        rise_tick = phase_end && !sclk_q;
        cnt_d     = (!run || phase_end) ? '0 : cnt_q + 1'b1;
        sclk_d    = sclk_q;
        if (!run) begin
            sclk_d = 1'b1;
        end else if (fall_tick) begin
            sclk_d = 1'b0;
        end else if (rise_tick) begin
            sclk_d = 1'b1;
        end
    end

    // Counter and SCLK registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/adc128s022_spi_reader.sv
// SPI master for the ADC128S022: sends the channel address, collects the
// 12-bit conversion and presents it with its channel tag to the PIO.
module adc128s022_spi_reader
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        channel,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic              adc_din,
    input  logic              adc_dout,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        data_channel,
    output logic              data_valid,
    output logic              busy
);

    state_t                state_q, state_d;
    logic [BIT_IDX_W-1:0]  bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [2:0]            req_ch_q, req_ch_d;
    logic [2:0]            conv_ch_q, conv_ch_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic [2:0]            data_ch_q, data_ch_d;
    logic                  valid_q, valid_d;
    logic                  din_q, din_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sync1_q, sync2_q;

    logic phase_end, fall_tick, rise_tick, sclk;
    logic run, fall_ok, frame_end, frame_start;

    assign run       = (state_q != IDLE);
    // The last high phase only falls again when another frame follows.
    assign fall_ok   = (state_q == CS_SETUP) ||
                       ((state_q == SHIFT) && ((bit_q != '0) || enable));
    assign frame_end = (state_q == SHIFT) && (bit_q == '0) && phase_end && sclk;

    adc_spi_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .fall_ok   (fall_ok),
        .phase_end (phase_end),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick),
        .sclk      (sclk)
    );

    // Frame sequencing, DIN/DOUT shifting and the channel pipeline.
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        req_ch_d    = req_ch_q;
        conv_ch_d   = conv_ch_q;
        data_out_d  = data_out_q;
        data_ch_d   = data_ch_q;
        valid_d     = 1'b0;
        din_d       = din_q;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = CS_SETUP;
                    // First frame after a CS fall always converts IN0.
                    conv_ch_d = 3'd0;
                end
            end
            CS_SETUP: begin
                if (phase_end) state_d = SHIFT;
            end
            SHIFT: begin
                if (frame_end && !enable) state_d = CS_HOLD;
            end
            CS_HOLD: begin
                if (phase_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fall_tick) begin
            frame_start = (state_q == CS_SETUP) || (bit_q == '0);
            bit_d       = frame_start ? BIT_IDX_W'(FRAME_BITS - 1) : bit_q - 1'b1;
            if (frame_start) req_ch_d = channel;
            din_d = frame_bit(bit_d, req_ch_q);
        end

        if (rise_tick) begin
            shift_d = {shift_q[FRAME_BITS-2:0], sync2_q};
        end

        if (frame_end) begin
            data_out_d = shift_q[FRAME_BITS-LEAD_ZEROS-1:0];
            data_ch_d  = conv_ch_q;
            valid_d    = 1'b1;
            conv_ch_d  = req_ch_q;
        end

        cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
    end

    // State and output registers, plus the adc_dout synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            req_ch_q   <= '0;
            conv_ch_q  <= '0;
            data_out_q <= '0;
            data_ch_q  <= '0;
            valid_q    <= 1'b0;
            din_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            req_ch_q   <= req_ch_d;
            conv_ch_q  <= conv_ch_d;
            data_out_q <= data_out_d;
            data_ch_q  <= data_ch_d;
            valid_q    <= valid_d;
            din_q      <= din_d;
            cs_n_q     <= cs_n_d;
            sync1_q    <= adc_dout;
            sync2_q    <= sync1_q;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk;
    assign adc_din      = din_q;
    assign data_out     = data_out_q;
    assign data_channel = data_ch_q;
    assign data_valid   = valid_q;
    assign busy         = !cs_n_q;

endmodule
